// File: rtl/vga_mode_table_if.sv
// Bundle for the VGA mode table: request handshake, frame boundary strobe,
// applied timing/pixel-clock outputs, status pulses and (only when
// VGA_MODE_TABLE_WR_EN is defined) the table write port.
interface vga_mode_table_if #(
    parameter int IDX_W = 2,
    parameter int H_W   = 12,
    parameter int V_W   = 11
);
    logic [IDX_W-1:0] mode_i;
    logic             req_i;
    logic             ready_o;
    logic             frame_end_i;
    logic [H_W-1:0]   hd_o, hf_o, hr_o, hb_o;
    logic [V_W-1:0]   vd_o, vf_o, vr_o, vb_o;
    logic [7:0]       freq_int_o;
    logic [7:0]       freq_frac_o;
    logic [IDX_W-1:0] mode_o;
    logic             valid_o;
    logic             done_o;
    logic             freq_chg_o;
    logic             err_o;
`ifdef VGA_MODE_TABLE_WR_EN
    logic             wr_en_i;
    logic [IDX_W-1:0] wr_idx_i;
    logic [3:0]       wr_field_i;
    logic [15:0]      wr_data_i;
`endif

    modport master (
        output mode_i, req_i, frame_end_i,
`ifdef VGA_MODE_TABLE_WR_EN
        output wr_en_i, wr_idx_i, wr_field_i, wr_data_i,
`endif
        input  ready_o, hd_o, hf_o, hr_o, hb_o, vd_o, vf_o, vr_o, vb_o,
        input  freq_int_o, freq_frac_o, mode_o, valid_o, done_o, freq_chg_o, err_o
    );

    modport slave (
        input  mode_i, req_i, frame_end_i,
`ifdef VGA_MODE_TABLE_WR_EN
        input  wr_en_i, wr_idx_i, wr_field_i, wr_data_i,
`endif
        output ready_o, hd_o, hf_o, hr_o, hb_o, vd_o, vf_o, vr_o, vb_o,
        output freq_int_o, freq_frac_o, mode_o, valid_o, done_o, freq_chg_o, err_o
    );
endinterface

// File: rtl/vga_mode_table.sv
// VGA timing mode table. A requested mode is latched in IDLE and applied to
// the registered outputs at the next frame boundary (or immediately when no
// mode is active yet). Define VGA_MODE_TABLE_WR_EN to make the table
// runtime-writable registers; otherwise it is a constant ROM of defaults.
module vga_mode_table #(
    parameter int RES_NUM = 4,
    parameter int H_W     = 12,
    parameter int V_W     = 11
) (
    input logic              clk_i,
    input logic              rst_i,
    vga_mode_table_if.slave  bus
);
    localparam int IDX_W = (RES_NUM > 1) ? $clog2(RES_NUM) : 1;
    localparam logic [IDX_W:0] RES_NUM_X = (IDX_W + 1)'(RES_NUM);

    typedef struct packed {
        logic [H_W-1:0] hd, hf, hr, hb;
        logic [V_W-1:0] vd, vf, vr, vb;
        logic [15:0]    freq;   // {int, frac/256} MHz
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} state_t;

    function automatic entry_t default_entry(input logic [IDX_W-1:0] idx);
        entry_t e;
        if (idx == IDX_W'(0)) begin
            e.hd = H_W'(800);  e.hf = H_W'(40); e.hr = H_W'(128); e.hb = H_W'(88);
            e.vd = V_W'(600);  e.vf = V_W'(1);  e.vr = V_W'(4);   e.vb = V_W'(23);
            e.freq = {8'd40, 8'd0};
        end else if (idx == IDX_W'(1)) begin
            e.hd = H_W'(1280); e.hf = H_W'(48); e.hr = H_W'(112); e.hb = H_W'(248);
            e.vd = V_W'(1024); e.vf = V_W'(1);  e.vr = V_W'(3);   e.vb = V_W'(38);
            e.freq = {8'd108, 8'd0};
        end else begin
            e.hd = H_W'(640);  e.hf = H_W'(16); e.hr = H_W'(96);  e.hb = H_W'(48);
            e.vd = V_W'(480);  e.vf = V_W'(10); e.vr = V_W'(2);   e.vb = V_W'(33);
            e.freq = {8'd25, 8'd45};
        end
        return e;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    entry_t           cur_q, cur_d;
    logic [IDX_W-1:0] mode_q, mode_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic             req_bad;
    logic             wr_bad;
    entry_t           rd_entry;

    assign req_bad = ({1'b0, bus.mode_i} >= RES_NUM_X);

`ifdef VGA_MODE_TABLE_WR_EN
    entry_t tbl_q [RES_NUM];

    assign wr_bad   = bus.wr_en_i && ({1'b0, bus.wr_idx_i} >= RES_NUM_X);
    // Registered table reads in APPLY see the pre-edge contents, so a write
    // landing in the APPLY cycle only takes effect for later applies.
    assign rd_entry = tbl_q[idx_q];

    // Table storage: reset to defaults, field writes at the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RES_NUM; i++) begin
                tbl_q[i] <= default_entry(IDX_W'(i));
            end
        end else if (bus.wr_en_i && !wr_bad) begin
            case (bus.wr_field_i)
                4'd0: tbl_q[bus.wr_idx_i].hd   <= H_W'(bus.wr_data_i);
                4'd1: tbl_q[bus.wr_idx_i].hf   <= H_W'(bus.wr_data_i);
                4'd2: tbl_q[bus.wr_idx_i].hr   <= H_W'(bus.wr_data_i);
                4'd3: tbl_q[bus.wr_idx_i].hb   <= H_W'(bus.wr_data_i);
                4'd4: tbl_q[bus.wr_idx_i].vd   <= V_W'(bus.wr_data_i);
                4'd5: tbl_q[bus.wr_idx_i].vf   <= V_W'(bus.wr_data_i);
                4'd6: tbl_q[bus.wr_idx_i].vr   <= V_W'(bus.wr_data_i);
                4'd7: tbl_q[bus.wr_idx_i].vb   <= V_W'(bus.wr_data_i);
                4'd8: tbl_q[bus.wr_idx_i].freq <= bus.wr_data_i;
                default: ;
            endcase
        end
    end
`else
    assign wr_bad   = 1'b0;
    assign rd_entry = default_entry(idx_q);
`endif

    // Next-state and output computation for the request/apply FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        chg_d   = 1'b0;
        err_d   = wr_bad;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = bus.mode_i;
                        state_d = valid_q ? ST_PENDING : ST_APPLY;
                    end
                end
            end
            ST_PENDING: begin
                if (bus.frame_end_i) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                cur_d   = rd_entry;
                mode_d  = idx_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                chg_d   = !valid_q || (rd_entry.freq != cur_q.freq);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_o     = (state_q == ST_IDLE);
    assign bus.hd_o        = cur_q.hd;
    assign bus.hf_o        = cur_q.hf;
    assign bus.hr_o        = cur_q.hr;
    assign bus.hb_o        = cur_q.hb;
    assign bus.vd_o        = cur_q.vd;
    assign bus.vf_o        = cur_q.vf;
    assign bus.vr_o        = cur_q.vr;
    assign bus.vb_o        = cur_q.vb;
    assign bus.freq_int_o  = cur_q.freq[15:8];
    assign bus.freq_frac_o = cur_q.freq[7:0];
    assign bus.mode_o      = mode_q;
    assign bus.valid_o     = valid_q;
    assign bus.done_o      = done_q;
    assign bus.freq_chg_o  = chg_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_vga_mode_table.sv
// Directed bench for vga_mode_table (RES_NUM=3). The write-port scenario is
// compiled in only when VGA_MODE_TABLE_WR_EN is defined.
module tb_vga_mode_table;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    vga_mode_table_if #(.IDX_W(2), .H_W(12), .V_W(11)) bus ();

    vga_mode_table #(.RES_NUM(3), .H_W(12), .V_W(11)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (bus.hd_o !== 12'd0) begin tests_failed++; $display("FAIL rst_hd: got %0d expected 0", bus.hd_o); end
        tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", bus.valid_o); end
        tests_run++; if (bus.ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b expected 1", bus.ready_o); end
        tests_run++; if ({bus.done_o, bus.err_o, bus.freq_chg_o} !== 3'b000) begin tests_failed++; $display("FAIL rst_pulses: got %b expected 000", {bus.done_o, bus.err_o, bus.freq_chg_o}); end
    endtask

    task automatic test_first_mode();
        bus.mode_i = 2'd0; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        tests_run++; if ({bus.ready_o, bus.done_o} !== 2'b00) begin tests_failed++; $display("FAIL first_busy: got %b expected 00", {bus.ready_o, bus.done_o}); end
        tick();
        tests_run++; if (bus.hd_o !== 12'd800 || bus.vb_o !== 11'd23) begin tests_failed++; $display("FAIL first_timing: got hd %0d vb %0d expected 800 23", bus.hd_o, bus.vb_o); end
        tests_run++; if (bus.freq_int_o !== 8'd40) begin tests_failed++; $display("FAIL first_freq: got %0d expected 40", bus.freq_int_o); end
        tests_run++; if ({bus.valid_o, bus.done_o, bus.freq_chg_o} !== 3'b111) begin tests_failed++; $display("FAIL first_flags: got %b expected 111", {bus.valid_o, bus.done_o, bus.freq_chg_o}); end
        tick();
        tests_run++; if ({bus.done_o, bus.ready_o} !== 2'b01) begin tests_failed++; $display("FAIL first_after: got %b expected 01", {bus.done_o, bus.ready_o}); end
    endtask

    task automatic test_pending();
        int bad = 0;
        bus.mode_i = 2'd1; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.hd_o !== 12'd800 || bus.done_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL pend_hold: got %0d bad cycles expected 0", bad); end
        bus.frame_end_i = 1'b1;
        tick();
        bus.frame_end_i = 1'b0;
        tests_run++; if (bus.hd_o !== 12'd800 || bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL pend_apply_cycle: got hd %0d done %b expected 800 0", bus.hd_o, bus.done_o); end
        tick();
        tests_run++; if (bus.hd_o !== 12'd1280 || bus.vd_o !== 11'd1024) begin tests_failed++; $display("FAIL pend_timing: got hd %0d vd %0d expected 1280 1024", bus.hd_o, bus.vd_o); end
        tests_run++; if (bus.freq_int_o !== 8'd108 || bus.mode_o !== 2'd1) begin tests_failed++; $display("FAIL pend_freq_mode: got %0d %0d expected 108 1", bus.freq_int_o, bus.mode_o); end
        tests_run++; if ({bus.done_o, bus.freq_chg_o} !== 2'b11) begin tests_failed++; $display("FAIL pend_flags: got %b expected 11", {bus.done_o, bus.freq_chg_o}); end
        tick();
    endtask

    task automatic test_bad_index();
        bus.mode_i = 2'd3; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        tests_run++; if ({bus.err_o, bus.ready_o} !== 2'b11) begin tests_failed++; $display("FAIL bad_err: got %b expected 11", {bus.err_o, bus.ready_o}); end
        tick();
        tests_run++; if (bus.err_o !== 1'b0 || bus.hd_o !== 12'd1280 || bus.mode_o !== 2'd1) begin tests_failed++; $display("FAIL bad_after: got err %b hd %0d mode %0d expected 0 1280 1", bus.err_o, bus.hd_o, bus.mode_o); end
        bus.mode_i = 2'd2; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        tick();
        bus.frame_end_i = 1'b1;
        tick();
        bus.frame_end_i = 1'b0;
        tick();
        tests_run++; if (bus.vd_o !== 11'd480 || bus.freq_frac_o !== 8'd45 || bus.freq_int_o !== 8'd25) begin tests_failed++; $display("FAIL mode2_vals: got vd %0d %0d.%0d expected 480 25.45", bus.vd_o, bus.freq_int_o, bus.freq_frac_o); end
        tests_run++; if ({bus.done_o, bus.freq_chg_o, bus.mode_o} !== 4'b1110) begin tests_failed++; $display("FAIL mode2_flags: got %b expected 1110", {bus.done_o, bus.freq_chg_o, bus.mode_o}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        bus.mode_i = 2'd0; bus.req_i = 1'b1;
        tick();                         // accepted -> PENDING
        bus.frame_end_i = 1'b1;
        tick();                         // PENDING -> APPLY
        dones += int'(bus.done_o);
        tick();                         // second frame_end pulse lands in APPLY
        bus.frame_end_i = 1'b0;
        dones += int'(bus.done_o);
        tests_run++; if ({bus.ready_o, bus.freq_chg_o, bus.hd_o} !== {1'b1, 1'b1, 12'd800}) begin tests_failed++; $display("FAIL b2b_applied: got ready %b chg %b hd %0d expected 1 1 800", bus.ready_o, bus.freq_chg_o, bus.hd_o); end
        tick();                         // held req re-accepted from IDLE
        bus.req_i = 1'b0;
        dones += int'(bus.done_o);
        tests_run++; if (bus.ready_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_reaccept: got ready %b expected 0", bus.ready_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(bus.done_o);
        end
        tests_run++; if (dones !== 1) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
        bus.frame_end_i = 1'b1;
        tick();
        bus.frame_end_i = 1'b0;
        tick();
        tests_run++; if ({bus.done_o, bus.freq_chg_o} !== 2'b10 || bus.hd_o !== 12'd800) begin tests_failed++; $display("FAIL same_mode: got done/chg %b hd %0d expected 10 800", {bus.done_o, bus.freq_chg_o}, bus.hd_o); end
        tick();
    endtask

    task automatic test_reset_pending();
        int dones = 0;
        bus.mode_i = 2'd1; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if ({bus.valid_o, bus.ready_o} !== 2'b01 || bus.hd_o !== 12'd0) begin tests_failed++; $display("FAIL rstpend_state: got valid/ready %b hd %0d expected 01 0", {bus.valid_o, bus.ready_o}, bus.hd_o); end
        bus.frame_end_i = 1'b1;
        tick();
        bus.frame_end_i = 1'b0;
        dones += int'(bus.done_o);
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(bus.done_o);
        end
        tests_run++; if (dones !== 0 || bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstpend_nodone: got dones %0d valid %b expected 0 0", dones, bus.valid_o); end
    endtask

`ifdef VGA_MODE_TABLE_WR_EN
    task automatic test_write();
        bus.wr_en_i = 1'b1; bus.wr_idx_i = 2'd2; bus.wr_field_i = 4'd0; bus.wr_data_i = 16'd1920;
        tick();
        bus.wr_field_i = 4'd8; bus.wr_data_i = 16'h9480;
        tick();
        bus.wr_idx_i = 2'd3; bus.wr_field_i = 4'd0; bus.wr_data_i = 16'd100;
        tick();
        bus.wr_en_i = 1'b0;
        tests_run++; if (bus.err_o !== 1'b1) begin tests_failed++; $display("FAIL wr_bad_err: got %b expected 1", bus.err_o); end
        bus.mode_i = 2'd2; bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        tick();
        tests_run++; if (bus.hd_o !== 12'd1920 || bus.vd_o !== 11'd480) begin tests_failed++; $display("FAIL wr_timing: got hd %0d vd %0d expected 1920 480", bus.hd_o, bus.vd_o); end
        tests_run++; if (bus.freq_int_o !== 8'd148 || bus.freq_frac_o !== 8'd128) begin tests_failed++; $display("FAIL wr_freq: got %0d.%0d expected 148.128", bus.freq_int_o, bus.freq_frac_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        tick();
        tests_run++; if (bus.hd_o !== 12'd640 || bus.freq_int_o !== 8'd25) begin tests_failed++; $display("FAIL wr_reset_default: got hd %0d freq %0d expected 640 25", bus.hd_o, bus.freq_int_o); end
    endtask
`endif

    initial begin
        bus.mode_i = '0;
        bus.req_i = 1'b0;
        bus.frame_end_i = 1'b0;
`ifdef VGA_MODE_TABLE_WR_EN
        bus.wr_en_i = 1'b0;
        bus.wr_idx_i = '0;
        bus.wr_field_i = '0;
        bus.wr_data_i = '0;
`endif
        test_reset();
        test_first_mode();
        test_pending();
        test_bad_index();
        test_back_to_back();
        test_reset_pending();
`ifdef VGA_MODE_TABLE_WR_EN
        test_write();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
